// File: rtl/cpu_regfile_pkg.sv
// cpu_regfile_pkg: shared register-file widths and types for decode, writeback and the bank
package cpu_regfile_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: registered read port with write-first forwarding and zero-reg override (clk, reset_n, rd_req/raddr in, write bus snoop, entry value in, rdata/rvalid out)
module regfile_read_port
  import cpu_regfile_pkg::*;
#(
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] entry,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);
  data_t sel;
  data_t rdata_d, rdata_q;
  logic  rvalid_d, rvalid_q;
  always_comb begin
    sel = (ZERO_REG && raddr == '0) ? '0 : (we && waddr == raddr) ? wdata : entry;
    rdata_d = rd_req ? sel : rdata_q;
    rvalid_d = rd_req;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign rdata = rdata_q;
  assign rvalid = rvalid_q;
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 16x16 register bank, one write port (we/waddr/wdata), two registered read ports A/B (rd_req/raddr in, rdata/rvalid out), async active-low reset
module regfile_2r1w
  import cpu_regfile_pkg::*;
#(
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_req_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  input  logic              rd_req_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b
);
  data_t [NUM_REGS-1:0] mem_d, mem_q;
  always_comb begin
    mem_d = mem_q;
    if (we && !(ZERO_REG && waddr == '0)) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mem_q <= '0;
    else mem_q <= mem_d;
  end
  regfile_read_port #(.ZERO_REG(ZERO_REG)) u_port_a (
    .clk(clk), .reset(reset), .rd_req(rd_req_a), .raddr(raddr_a),
    .we(we), .waddr(waddr), .wdata(wdata), .entry(mem_q[raddr_a]),
    .rdata(rdata_a), .rvalid(rvalid_a)
  );
  regfile_read_port #(.ZERO_REG(ZERO_REG)) u_port_b (
    .clk(clk), .reset(reset), .rd_req(rd_req_b), .raddr(raddr_b),
    .we(we), .waddr(waddr), .wdata(wdata), .entry(mem_q[raddr_b]),
    .rdata(rdata_b), .rvalid(rvalid_b)
  );
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: table-driven scoreboard bench for regfile_2r1w with ZERO_REG=0 and ZERO_REG=1 instances
module tb_regfile_2r1w;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic we = 1'b0;
  logic [3:0] waddr = '0;
  logic [15:0] wdata = '0;
  logic rd_req_a = 1'b0, rd_req_b = 1'b0;
  logic [3:0] raddr_a = '0, raddr_b = '0;
  logic [15:0] rdata_a0, rdata_b0, rdata_az, rdata_bz;
  logic rvalid_a0, rvalid_b0, rvalid_az, rvalid_bz;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  regfile_2r1w dut0 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_req_a(rd_req_a), .raddr_a(raddr_a), .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
    .rd_req_b(rd_req_b), .raddr_b(raddr_b), .rdata_b(rdata_b0), .rvalid_b(rvalid_b0)
  );
  regfile_2r1w #(.ZERO_REG(1'b1)) dutz (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_req_a(rd_req_a), .raddr_a(raddr_a), .rdata_a(rdata_az), .rvalid_a(rvalid_az),
    .rd_req_b(rd_req_b), .raddr_b(raddr_b), .rdata_b(rdata_bz), .rvalid_b(rvalid_bz)
  );
  typedef struct {
    logic we; logic [3:0] wa; logic [15:0] wd;
    logic ra; logic [3:0] aa; logic rb; logic [3:0] ab;
    logic [15:0] ea; logic [15:0] eb;
  } vec_t;
  typedef struct { logic [15:0] d0; logic [15:0] dz; } exp_t;
  exp_t qa[$], qb[$];
  logic [15:0] last_a0 = '0, last_az = '0, last_b0 = '0, last_bz = '0;
  vec_t tbl[13];
  task automatic cmp(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic check_idle_zero(input string n);
    cmp({n, "_da0"}, rdata_a0, 16'h0); cmp({n, "_db0"}, rdata_b0, 16'h0);
    cmp({n, "_daz"}, rdata_az, 16'h0); cmp({n, "_dbz"}, rdata_bz, 16'h0);
    cmp({n, "_va0"}, {15'h0, rvalid_a0}, 16'h0); cmp({n, "_vb0"}, {15'h0, rvalid_b0}, 16'h0);
    cmp({n, "_vaz"}, {15'h0, rvalid_az}, 16'h0); cmp({n, "_vbz"}, {15'h0, rvalid_bz}, 16'h0);
  endtask
  task automatic drive(input vec_t v, input string n);
    exp_t e;
    we = v.we; waddr = v.wa; wdata = v.wd;
    rd_req_a = v.ra; raddr_a = v.aa; rd_req_b = v.rb; raddr_b = v.ab;
    if (v.ra) qa.push_back('{v.ea, (v.aa == 4'd0) ? 16'h0 : v.ea});
    if (v.rb) qb.push_back('{v.eb, (v.ab == 4'd0) ? 16'h0 : v.eb});
    @(posedge clk);
    #1;
    if (rvalid_a0 && qa.size() > 0) begin
      e = qa.pop_front(); last_a0 = e.d0; last_az = e.dz;
    end
    if (rvalid_b0 && qb.size() > 0) begin
      e = qb.pop_front(); last_b0 = e.d0; last_bz = e.dz;
    end
    cmp({n, "_va0"}, {15'h0, rvalid_a0}, {15'h0, v.ra});
    cmp({n, "_vaz"}, {15'h0, rvalid_az}, {15'h0, v.ra});
    cmp({n, "_vb0"}, {15'h0, rvalid_b0}, {15'h0, v.rb});
    cmp({n, "_vbz"}, {15'h0, rvalid_bz}, {15'h0, v.rb});
    cmp({n, "_da0"}, rdata_a0, last_a0);
    cmp({n, "_daz"}, rdata_az, last_az);
    cmp({n, "_db0"}, rdata_b0, last_b0);
    cmp({n, "_dbz"}, rdata_bz, last_bz);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0,    16'h0};
    tbl[1]  = '{1'b1, 4'd7, 16'h1111, 1'b1, 4'd3, 1'b0, 4'd0, 16'hBEEF, 16'h0};
    tbl[2]  = '{1'b1, 4'd2, 16'h00AA, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0,    16'h0};
    tbl[3]  = '{1'b1, 4'd7, 16'h2222, 1'b1, 4'd7, 1'b1, 4'd7, 16'h2222, 16'h2222};
    tbl[4]  = '{1'b0, 4'd0, 16'h0,    1'b1, 4'd2, 1'b1, 4'd7, 16'h00AA, 16'h2222};
    tbl[5]  = '{1'b1, 4'd2, 16'h5555, 1'b0, 4'd2, 1'b1, 4'd3, 16'h0,    16'hBEEF};
    tbl[6]  = '{1'b1, 4'd2, 16'h5555, 1'b0, 4'd2, 1'b0, 4'd0, 16'h0,    16'h0};
    tbl[7]  = '{1'b1, 4'd2, 16'h5555, 1'b0, 4'd2, 1'b0, 4'd0, 16'h0,    16'h0};
    tbl[8]  = '{1'b0, 4'd0, 16'h0,    1'b1, 4'd2, 1'b0, 4'd0, 16'h5555, 16'h0};
    tbl[9]  = '{1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0, 16'hFFFF, 16'hFFFF};
    tbl[10] = '{1'b1, 4'd0, 16'h1234, 1'b1, 4'd0, 1'b1, 4'd0, 16'h1234, 16'h1234};
    tbl[11] = '{1'b1, 4'd5, 16'h5555, 1'b1, 4'd6, 1'b1, 4'd5, 16'h0000, 16'h5555};
    tbl[12] = '{1'b0, 4'd5, 16'h9999, 1'b1, 4'd5, 1'b1, 4'd0, 16'h5555, 16'h1234};
    #12;
    check_idle_zero("por");
    #1 reset = 1'b1;
    for (int i = 0; i < 13; i++) drive(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 16; i++)
      drive('{1'b1, 4'(i), 16'(16'h0100 + i), 1'b0, 4'd0, 1'b0, 4'd0, 16'h0, 16'h0}, $sformatf("fill%0d", i));
    for (int i = 0; i < 16; i++)
      drive('{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'(i), 16'h0, 16'(16'h0100 + i)}, $sformatf("strm%0d", i));
    we = 1'b0; rd_req_a = 1'b0; rd_req_b = 1'b0;
    #3 reset = 1'b0;
    #1 check_idle_zero("arst");
    @(posedge clk);
    #1 check_idle_zero("hold_rst");
    #3 reset = 1'b1;
    last_a0 = '0; last_az = '0; last_b0 = '0; last_bz = '0;
    qa.delete(); qb.delete();
    drive('{1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b1, 4'd3, 16'h0000, 16'h0000}, "post_rst");
    drive('{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0, 16'h0}, "post_idle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Register bank: 16 entries x 16 bits, one synchronous write port, two independent registered read ports (A, B).
- Sits between the CPU decode stage, which issues the read requests, and the writeback stage, which drives the write port.
- Read data is returned one clock after the request.
- Same-cycle write-to-read forwarding is built in, so the pipeline needs no external bypass mux for writeback-to-decode hazards.

Parameters:
DATA_W, 16, width of each register and of every data port
ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W
ZERO_REG, 0, when 1, entry 0 is hard-wired: reads return 0 and writes to it are dropped

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
we  input  1  write enable, sampled at rising edge
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
rd_req_a  input  1  port A read request
raddr_a  input  ADDR_W  port A read address
rdata_a  output  DATA_W  port A read data, registered
rvalid_a  output  1  port A data valid, one-cycle pulse
rd_req_b  input  1  port B read request
raddr_b  input  ADDR_W  port B read address
rdata_b  output  DATA_W  port B read data, registered
rvalid_b  output  1  port B data valid, one-cycle pulse

Behaviour:
- Interface: one clock (clk). Reset (reset) is asynchronous and active-low.
- Reset asserted (reset=0): immediately, with no clock needed, all NUM_REGS entries go to 0, rdata_a/rdata_b go to 0 and rvalid_a/rvalid_b go to 0. State holds at these values while reset=0. Reset mid-operation cancels any in-flight read; no rvalid is produced for a request sampled in the cycle of reset assertion.
- Write: at a rising edge with we=1, entry[waddr] <= wdata. With we=0, every entry holds its value.
- Write to entry 0 when ZERO_REG=1: ignored, entry stays 0.
- Read, per port, independent and identical:
  - Request at edge N (rd_req=1) -> at edge N, rdata <= value selected for raddr and rvalid <= 1. Latency is one cycle.
  - No request at edge N -> rvalid <= 0 and rdata holds its previous value. rdata is never cleared except by reset.
  - Back-to-back requests on consecutive cycles produce consecutive rvalid pulses. No backpressure: the consumer always accepts.
- Value selection, in priority order:
  1. ZERO_REG=1 and raddr=0: 0.
  2. we=1 and waddr==raddr in the same cycle: wdata (write-first forwarding).
  3. Otherwise: entry[raddr] as it stood before the edge.
- Both ports may read the same address in the same cycle. Both return the identical value, including the forwarded value.
- A read without a same-cycle write to that address returns the value stored as of the previous edge. A write at edge N is visible through the array from edge N+1 onward.
- All arithmetic is address compare only. No wrap-around: raddr/waddr cover exactly NUM_REGS entries.
- Contents are not observable through any port other than rdata_a/rdata_b.

Decomposition:
- Shared package cpu_regfile_pkg holds DATA_W, ADDR_W, NUM_REGS and the data/address typedefs. The same package is used by decode and writeback.
- One sub-module, regfile_read_port: forwarding compare, zero-reg override, rdata/rvalid registers. It is instantiated twice, for ports A and B.
- The storage array and write logic live in the top module.

Test Plan:
- Reset: drive writes, then reset=0 mid-cycle -> rdata_a=rdata_b=0 and rvalid_a=rvalid_b=0 asynchronously, before the next edge. After release, a read of entry 5 returns 0x0000.
- Write then read: we=1 waddr=3 wdata=0xBEEF at edge 1; rd_req_a=1 raddr_a=3 at edge 2 -> rdata_a=0xBEEF and rvalid_a=1 after edge 2, rvalid_a=0 after edge 3 if there is no request.
- Forwarding: entry 7 holds 0x1111; same cycle we=1 waddr=7 wdata=0x2222 and rd_req_a=rd_req_b=1 with raddr=7 -> both rdata=0x2222 next cycle.
- Hold: read entry 2 = 0x00AA, then rd_req_a=0 for 3 cycles while writing entry 2=0x5555 -> rdata_a stays 0x00AA and rvalid_a=0.
- ZERO_REG=1: write 0xFFFF to entry 0, then read entry 0 on both ports, including same-cycle forwarding -> rdata=0x0000. With ZERO_REG=0 the same sequence returns 0xFFFF.
- Streaming: port B reads entries 0..15 on consecutive cycles after a full fill with value = 0x0100 + index -> 16 consecutive rvalid_b pulses with matching data and no gaps.
